// File: rtl/mm_pkg.sv
// Shared definitions for the memory-access stage: op-field indices, access sizes,
// engine state encoding and the size-to-bytes helper.
package mm_pkg;

  localparam int unsigned LS_EN  = 4;
  localparam int unsigned LS_ST  = 1;
  localparam int unsigned LS_UNS = 0;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    FIN  = 2'd2
  } state_t;

  function automatic int unsigned nbytes(input logic [1:0] size);
    return 32'(size) + 32'd1;
  endfunction

endpackage

// File: rtl/mm_lsu_ext.sv
// Sign/zero extender for assembled load data: keeps the low nbytes(size) bytes
// and fills the upper bits with zeros or the top kept bit.
module mm_lsu_ext
  import mm_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] data,
  input  logic [1:0]      size,
  input  logic            uns,
  output logic [XLEN-1:0] ext
);

  int unsigned             sh;
  logic signed [XLEN-1:0]  left;

  // Left-justify the kept bytes, then shift back logically or arithmetically.
  always_comb begin
    sh   = XLEN - nbytes(size) * 32'd8;
    left = data << sh;
    if (uns)
      ext = left >> sh;
    else
      ext = left >>> sh;
  end

endmodule

// File: rtl/mm_lsu.sv
// Memory-access stage: combinational passthrough for non-memory ops, beat-wise
// load/store engine over a narrow memory-controller bus with pipeline stall.
module mm_lsu
  import mm_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned BUS_W    = 8,
  parameter int unsigned MIS_TRAP = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [4:0]       wa,
  input  logic [XLEN-1:0]  wn,
  input  logic [XLEN-1:0]  st_data,
  input  logic [4:0]       ls_op,
  output logic             we_o,
  output logic [4:0]       wa_o,
  output logic [XLEN-1:0]  wn_o,
  output logic             stall,
  output logic             mis,
  output logic             mem_req,
  output logic             mem_wr,
  output logic [31:0]      mem_addr,
  output logic [BUS_W-1:0] mem_wdata,
  input  logic [BUS_W-1:0] mem_rdata,
  input  logic             mem_ack
);

  localparam int unsigned BB = BUS_W / 8;

  state_t          state, state_nx;
  logic [1:0]      cnt;
  logic [XLEN-1:0] ld_buf;
  logic [XLEN-1:0] sd_q;
  logic [31:0]     base_q;
  logic [3:0]      op_q;
  logic            mis_q;
  logic            misaligned;
  logic            last_beat;
  logic [XLEN-1:0] ext_val;

  // NB is a power of two for every legal size, so the modulo reduces to a mask.
  assign misaligned = (wn[1:0] & 2'(nbytes(ls_op[3:2]) - 32'd1)) != 2'b00;
  assign last_beat  = (32'(cnt) + 32'd1) * BB >= nbytes(op_q[3:2]);

  mm_lsu_ext #(.XLEN(XLEN)) u_ext (
    .data (ld_buf),
    .size (op_q[3:2]),
    .uns  (op_q[LS_UNS]),
    .ext  (ext_val)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      ld_buf <= '0;
      sd_q   <= '0;
      base_q <= '0;
      op_q   <= '0;
      mis_q  <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (ls_op[LS_EN]) begin
          op_q   <= ls_op[3:0];
          base_q <= 32'(wn);
          sd_q   <= st_data;
          cnt    <= '0;
          ld_buf <= '0;
          mis_q  <= (MIS_TRAP != 0) && misaligned;
        end
        ACC: if (mem_ack) begin
          if (!op_q[LS_ST])
            ld_buf <= ld_buf | (XLEN'(mem_rdata) << (32'(cnt) * BUS_W));
          cnt <= cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx  = state;
    we_o      = 1'b0;
    wa_o      = '0;
    wn_o      = '0;
    stall     = 1'b0;
    mis       = 1'b0;
    mem_req   = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      IDLE: begin
        if (ls_op[LS_EN]) begin
          stall    = 1'b1;
          state_nx = ((MIS_TRAP != 0) && misaligned) ? FIN : ACC;
        end else begin
          we_o = we;
          wa_o = wa;
          wn_o = wn;
        end
      end
      ACC: begin
        stall     = 1'b1;
        mem_req   = 1'b1;
        mem_wr    = op_q[LS_ST];
        mem_addr  = base_q + 32'(cnt) * BB;
        mem_wdata = BUS_W'(sd_q >> (32'(cnt) * BUS_W));
        if (mem_ack && last_beat)
          state_nx = FIN;
      end
      FIN: begin
        wa_o     = wa;
        mis      = mis_q;
        state_nx = IDLE;
        if (mis_q || op_q[LS_ST]) begin
          wn_o = wn;
        end else begin
          wn_o = ext_val;
          we_o = we;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (rst) begin
      we_o      = 1'b0;
      wa_o      = '0;
      wn_o      = '0;
      stall     = 1'b0;
      mis       = 1'b0;
      mem_req   = 1'b0;
      mem_wr    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
    end
  end

endmodule
